// File: rtl/filtro_axil_regs_if.sv
// AXI4-Lite bundle for the filter register bank: the master modport issues requests,
// the slave modport answers them.
interface filtro_axil_regs_if #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
);
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
   logic [2:0]                      S_AXI_AWPROT;
   logic                            S_AXI_AWVALID;
   logic                            S_AXI_AWREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                            S_AXI_WVALID;
   logic                            S_AXI_WREADY;
   logic [1:0]                      S_AXI_BRESP;
   logic                            S_AXI_BVALID;
   logic                            S_AXI_BREADY;
   logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
   logic [2:0]                      S_AXI_ARPROT;
   logic                            S_AXI_ARVALID;
   logic                            S_AXI_ARREADY;
   logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
   logic [1:0]                      S_AXI_RRESP;
   logic                            S_AXI_RVALID;
   logic                            S_AXI_RREADY;

   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      output S_AXI_BREADY,
      output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      output S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );

   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
      input  S_AXI_BREADY,
      input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
      input  S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
      output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/filtro_axil_regs.sv
// AXI4-Lite control/status register bank for the filter IP (CTRL, COEF, DATA, STATUS).
// Optional FILTRO_AXIL_SLVERR_EN: SLVERR on word-3 writes and on misaligned accesses.
module filtro_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                          S_AXI_ACLK,
   input  logic                          S_AXI_ARESET,
   filtro_axil_regs_if.slave             axi,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg0_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg1_out,
   output logic [C_S_AXI_DATA_WIDTH-1:0] reg2_out,
   input  logic [C_S_AXI_DATA_WIDTH-1:0] status_in,
   output logic [3:0]                    wr_pulse
);
   localparam int DW = C_S_AXI_DATA_WIDTH;
   localparam int AW = C_S_AXI_ADDR_WIDTH;
   localparam int SW = DW / 8;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t      w_state, w_next;
   r_state_t      r_state, r_next;
   logic          alive;
   logic [AW-1:0] aw_addr_q;
   logic [DW-1:0] w_data_q;
   logic [SW-1:0] w_strb_q;
   logic [DW-1:0] regs [3];
   logic [1:0]    bresp_q;
   logic [1:0]    rresp_q;
   logic [DW-1:0] rdata_q;
   logic [3:0]    pulse_q;

   logic          commit, cap_a, cap_d;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_data;
   logic [SW-1:0] c_strb;
   logic [1:0]    c_word;
   logic          c_misaligned, c_err;
   logic          awready, wready, bvalid;
   logic          arready, rvalid, ar_hs;
   logic [DW-1:0] rd_val;
   logic          rd_err;
   logic          unused_bits;

   function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
      merge_bytes = old_val;
      for (int b = 0; b < SW; b++)
         if (strb[b]) merge_bytes[8*b +: 8] = new_val[8*b +: 8];
   endfunction

   // Ready outputs stay low until the first edge after reset releases (alive).
   // The commit address/data come from the bus or the capture regs, whichever arrived first.
   always_comb begin
      w_next  = w_state;
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      commit  = 1'b0;
      cap_a   = 1'b0;
      cap_d   = 1'b0;
      c_addr  = aw_addr_q;
      c_data  = w_data_q;
      c_strb  = w_strb_q;
      case (w_state)
         W_IDLE: begin
            awready = alive;
            wready  = alive;
            c_addr  = axi.S_AXI_AWADDR;
            c_data  = axi.S_AXI_WDATA;
            c_strb  = axi.S_AXI_WSTRB;
            if (alive && axi.S_AXI_AWVALID && axi.S_AXI_WVALID) begin
               commit = 1'b1;
               w_next = W_RESP;
            end else if (alive && axi.S_AXI_AWVALID) begin
               cap_a  = 1'b1;
               w_next = W_HAVE_A;
            end else if (alive && axi.S_AXI_WVALID) begin
               cap_d  = 1'b1;
               w_next = W_HAVE_D;
            end
         end
         W_HAVE_A: begin
            wready = 1'b1;
            c_data = axi.S_AXI_WDATA;
            c_strb = axi.S_AXI_WSTRB;
            if (axi.S_AXI_WVALID) begin
               commit = 1'b1;
               w_next = W_RESP;
            end
         end
         W_HAVE_D: begin
            awready = 1'b1;
            c_addr  = axi.S_AXI_AWADDR;
            if (axi.S_AXI_AWVALID) begin
               commit = 1'b1;
               w_next = W_RESP;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (axi.S_AXI_BREADY) w_next = W_IDLE;
         end
      endcase
   end

   always_comb begin
      c_word       = c_addr[3:2];
      c_misaligned = 1'b0;
      c_err        = 1'b0;
`ifdef FILTRO_AXIL_SLVERR_EN
      c_misaligned = (c_addr[1:0] != 2'b00);
      c_err        = c_misaligned || (c_word == 2'd3);
`endif
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         w_state   <= W_IDLE;
         alive     <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= 2'b00;
         pulse_q   <= 4'b0000;
         for (int n = 0; n < 3; n++) regs[n] <= '0;
      end else begin
         alive   <= 1'b1;
         w_state <= w_next;
         pulse_q <= 4'b0000;
         if (cap_a) aw_addr_q <= axi.S_AXI_AWADDR;
         if (cap_d) begin
            w_data_q <= axi.S_AXI_WDATA;
            w_strb_q <= axi.S_AXI_WSTRB;
         end
         if (commit) begin
            bresp_q <= c_err ? 2'b10 : 2'b00;
            if (!c_err) pulse_q <= 4'b0001 << c_word;
         end
         for (int n = 0; n < 3; n++)
            if (commit && !c_misaligned && c_word == 2'(n))
               regs[n] <= merge_bytes(regs[n], c_data, c_strb);
      end
   end

   always_comb begin
      r_next  = r_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = alive;
            if (alive && axi.S_AXI_ARVALID) r_next = R_DATA;
         end
         R_DATA: begin
            rvalid = 1'b1;
            if (axi.S_AXI_RREADY) r_next = R_IDLE;
         end
      endcase
      ar_hs = arready && axi.S_AXI_ARVALID;
   end

   // Read mux samples the registers before any same-edge write lands.
   always_comb begin
      rd_err = 1'b0;
      case (axi.S_AXI_ARADDR[3:2])
         2'd0:    rd_val = regs[0];
         2'd1:    rd_val = regs[1];
         2'd2:    rd_val = regs[2];
         default: rd_val = status_in;
      endcase
`ifdef FILTRO_AXIL_SLVERR_EN
      if (axi.S_AXI_ARADDR[1:0] != 2'b00) begin
         rd_err = 1'b1;
         rd_val = '0;
      end
`endif
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_state <= R_IDLE;
         rdata_q <= '0;
         rresp_q <= 2'b00;
      end else begin
         r_state <= r_next;
         if (ar_hs) begin
            rdata_q <= rd_val;
            rresp_q <= rd_err ? 2'b10 : 2'b00;
         end
      end
   end

   assign axi.S_AXI_AWREADY = awready;
   assign axi.S_AXI_WREADY  = wready;
   assign axi.S_AXI_BVALID  = bvalid;
   assign axi.S_AXI_BRESP   = bresp_q;
   assign axi.S_AXI_ARREADY = arready;
   assign axi.S_AXI_RVALID  = rvalid;
   assign axi.S_AXI_RDATA   = rdata_q;
   assign axi.S_AXI_RRESP   = rresp_q;
   assign reg0_out          = regs[0];
   assign reg1_out          = regs[1];
   assign reg2_out          = regs[2];
   assign wr_pulse          = pulse_q;

   assign unused_bits = ^{axi.S_AXI_AWPROT, axi.S_AXI_ARPROT, axi.S_AXI_ARADDR[1:0], c_addr[1:0]};
endmodule

// File: tb/tb_filtro_axil_regs.sv
// Bench for filtro_axil_regs: directed scenarios plus random traffic checked
// against a behavioural register-map model.
module tb_filtro_axil_regs;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] reg0_out, reg1_out, reg2_out;
   logic [31:0] status_in;
   logic [3:0]  wr_pulse;

   filtro_axil_regs_if axi ();

   filtro_axil_regs dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESET (rst),
      .axi          (axi),
      .reg0_out     (reg0_out),
      .reg1_out     (reg1_out),
      .reg2_out     (reg2_out),
      .status_in    (status_in),
      .wr_pulse     (wr_pulse)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          fails  = 0;
   logic [31:0] mReg [3];
   logic [3:0]  expPulse = 4'b0000;
   bit          cmpOn = 1'b0;
   logic [1:0]  lastBresp;
   logic [31:0] got;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeoutFail(input string name);
      checks++;
      fails++;
      $display("[TB] FAIL %s: got timeout expected handshake at %0t", name, $time);
   endtask

   // Register-map model: what a write does to the bank, and what its response is
   task automatic modelWrite(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
      int w;
      w    = int'(addr[3:2]);
      resp = 2'b00;
`ifdef FILTRO_AXIL_SLVERR_EN
      if (addr[1:0] != 2'b00 || w == 3) begin
         resp = 2'b10;
         return;
      end
`endif
      expPulse = 4'b0001 << w;
      if (w < 3)
         for (int b = 0; b < 4; b++)
            if (strb[b]) mReg[w][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic modelRead(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int w;
      w    = int'(addr[3:2]);
      resp = 2'b00;
      data = (w == 3) ? status_in : mReg[w];
`ifdef FILTRO_AXIL_SLVERR_EN
      if (addr[1:0] != 2'b00) begin
         data = 32'h0;
         resp = 2'b10;
      end
`endif
   endtask

   // Called at a negedge; returns at a negedge with the bus idle
   task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awDelay, input int wDelay, input int bDelay);
      bit awDone = 1'b0, wDone = 1'b0, awHs, wHs;
      int cyc = 0;
      logic [1:0] expResp = 2'b00;
      while (!(awDone && wDone)) begin
         if (!awDone && cyc >= awDelay) begin
            axi.S_AXI_AWVALID = 1'b1;
            axi.S_AXI_AWADDR  = addr;
         end
         if (!wDone && cyc >= wDelay) begin
            axi.S_AXI_WVALID = 1'b1;
            axi.S_AXI_WDATA  = data;
            axi.S_AXI_WSTRB  = strb;
         end
         checkOutput("bvalid_early", 32'(axi.S_AXI_BVALID), 0);
         awHs = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
         wHs  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
         @(posedge clk);
         awDone |= awHs;
         wDone  |= wHs;
         if (awDone && wDone) modelWrite(addr, data, strb, expResp);
         @(negedge clk);
         if (awHs) begin
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_AWADDR  = 4'($urandom);
         end
         if (wHs) begin
            axi.S_AXI_WVALID = 1'b0;
            axi.S_AXI_WDATA  = $urandom;
         end
         cyc++;
         if (cyc > 100) begin
            timeoutFail("write_handshake");
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
            return;
         end
      end
      lastBresp = axi.S_AXI_BRESP;
      checkOutput("bvalid_latency", 32'(axi.S_AXI_BVALID), 1);
      checkOutput("bresp", 32'(axi.S_AXI_BRESP), 32'(expResp));
      for (int i = 0; i < bDelay; i++) begin
         checkOutput("awready_in_resp", 32'(axi.S_AXI_AWREADY), 0);
         checkOutput("wready_in_resp", 32'(axi.S_AXI_WREADY), 0);
         @(negedge clk);
         checkOutput("bvalid_hold", 32'(axi.S_AXI_BVALID), 1);
         checkOutput("bresp_hold", 32'(axi.S_AXI_BRESP), 32'(expResp));
      end
      axi.S_AXI_BREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.S_AXI_BREADY = 1'b0;
      checkOutput("bvalid_clear", 32'(axi.S_AXI_BVALID), 0);
   endtask

   task automatic axiRead(input logic [3:0] addr, input int arDelay, input int rDelay,
                          output logic [31:0] data);
      int cyc = 0;
      logic [31:0] expData;
      logic [1:0]  expResp;
      data = 32'h0;
      repeat (arDelay) @(negedge clk);
      axi.S_AXI_ARVALID = 1'b1;
      axi.S_AXI_ARADDR  = addr;
      while (axi.S_AXI_ARREADY !== 1'b1) begin
         @(negedge clk);
         cyc++;
         if (cyc > 100) begin
            timeoutFail("read_handshake");
            axi.S_AXI_ARVALID = 1'b0;
            return;
         end
      end
      modelRead(addr, expData, expResp);
      @(posedge clk);
      @(negedge clk);
      axi.S_AXI_ARVALID = 1'b0;
      axi.S_AXI_ARADDR  = 4'($urandom);
      data = axi.S_AXI_RDATA;
      checkOutput("rvalid_latency", 32'(axi.S_AXI_RVALID), 1);
      checkOutput("rdata", axi.S_AXI_RDATA, expData);
      checkOutput("rresp", 32'(axi.S_AXI_RRESP), 32'(expResp));
      for (int i = 0; i < rDelay; i++) begin
         checkOutput("arready_in_data", 32'(axi.S_AXI_ARREADY), 0);
         @(negedge clk);
         checkOutput("rvalid_hold", 32'(axi.S_AXI_RVALID), 1);
         checkOutput("rdata_hold", axi.S_AXI_RDATA, expData);
         checkOutput("rresp_hold", 32'(axi.S_AXI_RRESP), 32'(expResp));
      end
      axi.S_AXI_RREADY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      axi.S_AXI_RREADY = 1'b0;
      checkOutput("rvalid_clear", 32'(axi.S_AXI_RVALID), 0);
   endtask

   // Every cycle: register outputs and write strobes must match the model
   initial begin
      wait (cmpOn);
      forever begin
         @(negedge clk);
         checkOutput("reg0_out", reg0_out, mReg[0]);
         checkOutput("reg1_out", reg1_out, mReg[1]);
         checkOutput("reg2_out", reg2_out, mReg[2]);
         checkOutput("wr_pulse", 32'(wr_pulse), 32'(expPulse));
         expPulse = 4'b0000;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Stimulus: directed scenarios first, then random traffic
   initial begin : applyStimulus
      logic [3:0] a;
      rst = 1'b1;
      status_in = 32'h0;
      axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWPROT = 3'b000;
      axi.S_AXI_WVALID  = 1'b0; axi.S_AXI_WDATA  = 32'h0; axi.S_AXI_WSTRB = 4'h0;
      axi.S_AXI_BREADY  = 1'b0;
      axi.S_AXI_ARVALID = 1'b0; axi.S_AXI_ARADDR = 4'h0; axi.S_AXI_ARPROT = 3'b000;
      axi.S_AXI_RREADY  = 1'b0;
      for (int n = 0; n < 3; n++) mReg[n] = 32'h0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_awready", 32'(axi.S_AXI_AWREADY), 0);
      checkOutput("rst_wready", 32'(axi.S_AXI_WREADY), 0);
      checkOutput("rst_arready", 32'(axi.S_AXI_ARREADY), 0);
      checkOutput("rst_bvalid", 32'(axi.S_AXI_BVALID), 0);
      checkOutput("rst_rvalid", 32'(axi.S_AXI_RVALID), 0);
      checkOutput("rst_rdata", axi.S_AXI_RDATA, 0);
      checkOutput("rst_resp", 32'({axi.S_AXI_BRESP, axi.S_AXI_RRESP}), 0);
      checkOutput("rst_reg0", reg0_out, 0);
      checkOutput("rst_pulse", 32'(wr_pulse), 0);
      rst = 1'b0;
      checkOutput("ready_before_edge", 32'(axi.S_AXI_AWREADY), 0);
      @(negedge clk);
      checkOutput("ready_after_edge", 32'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}), 32'h7);
      cmpOn = 1'b1;

      axiWrite(4'h0, 32'h1, 4'hF, 0, 0, 0);
      axiWrite(4'h4, 32'h2, 4'hF, 0, 0, 0);
      axiWrite(4'h8, 32'h3, 4'hF, 0, 0, 0);
      checkOutput("lit_reg2", reg2_out, 32'h3);
      axiRead(4'h0, 0, 0, got); checkOutput("lit_rd0", got, 32'h1);
      axiRead(4'h4, 0, 0, got); checkOutput("lit_rd1", got, 32'h2);
      axiRead(4'h8, 0, 0, got); checkOutput("lit_rd2", got, 32'h3);

      axiWrite(4'h4, 32'hA5A5A5A5, 4'hF, 3, 0, 0);
      axiWrite(4'h8, 32'h5A5A5A5A, 4'hF, 0, 3, 0);
      checkOutput("lit_w_first", reg1_out, 32'hA5A5A5A5);
      checkOutput("lit_aw_first", reg2_out, 32'h5A5A5A5A);

      axiWrite(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axiWrite(4'h4, 32'h12345678, 4'b0101, 0, 0, 0);
      axiRead(4'h4, 0, 0, got); checkOutput("lit_strobe", got, 32'hFF34FF78);

      status_in = 32'hCAFE0003;
      axiRead(4'hC, 0, 0, got); checkOutput("lit_status", got, 32'hCAFE0003);
      axiWrite(4'hC, 32'h5, 4'hF, 0, 0, 0);
`ifdef FILTRO_AXIL_SLVERR_EN
      checkOutput("lit_status_wr_resp", 32'(lastBresp), 32'h2);
`else
      checkOutput("lit_status_wr_resp", 32'(lastBresp), 32'h0);
`endif
      axiRead(4'hC, 0, 0, got); checkOutput("lit_status_after", got, 32'hCAFE0003);

      axiWrite(4'h8, 32'h0BADF00D, 4'hF, 0, 0, 10);
      axiRead(4'h8, 0, 10, got); checkOutput("lit_stall", got, 32'h0BADF00D);

      fork
         axiWrite(4'h4, 32'h55AA55AA, 4'hF, 0, 0, 0);
         axiRead(4'h4, 0, 0, got);
      join
      checkOutput("lit_same_cycle", got, 32'hFF34FF78);
      checkOutput("lit_same_cycle_reg", reg1_out, 32'h55AA55AA);

      axiWrite(4'h0, 32'hA, 4'hF, 0, 0, 0);
      checkOutput("lit_reg0_a", reg0_out, 32'hA);
      axi.S_AXI_AWVALID = 1'b1;
      axi.S_AXI_AWADDR  = 4'h0;
      @(posedge clk);
      @(negedge clk);
      axi.S_AXI_AWVALID = 1'b0;
      checkOutput("have_a_awready", 32'(axi.S_AXI_AWREADY), 0);
      checkOutput("have_a_wready", 32'(axi.S_AXI_WREADY), 1);
      rst = 1'b1;
      @(posedge clk);
      for (int n = 0; n < 3; n++) mReg[n] = 32'h0;
      expPulse = 4'b0000;
      @(negedge clk);
      checkOutput("midrst_reg0", reg0_out, 32'h0);
      checkOutput("midrst_bvalid", 32'(axi.S_AXI_BVALID), 0);
      checkOutput("midrst_awready", 32'(axi.S_AXI_AWREADY), 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_bvalid_after", 32'(axi.S_AXI_BVALID), 0);
      axiWrite(4'h0, 32'h600D, 4'hF, 0, 0, 0);
      axiRead(4'h0, 0, 0, got); checkOutput("lit_after_rst", got, 32'h600D);

      for (int k = 0; k < 80; k++) begin
         status_in = $urandom;
         a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 1) == 1)
            axiWrite(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            axiRead(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), got);
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/filtro_axil_regs.md
# filtro_axil_regs

AXI4-Lite responder (slave) for the filter IP's control/status register bank. It accepts single-beat writes and reads from a bus initiator, such as the interconnect master or the VIP master in the block bench. It exposes three read/write control registers and one read-only status register to the filter datapath. It also produces a one-cycle write-strobe per register so the datapath can react to writes.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 4, byte address width; word index = addr[3:2]
- S_AXI_ACLK  in  1  sole clock
- S_AXI_ARESET  in  1  reset, synchronous, active-high
- S_AXI_AWADDR  in  4  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  4  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- reg0_out, reg1_out, reg2_out  out  32 each  control register contents
- status_in  in  32  sampled on reads of word 3
- wr_pulse  out  4  one-cycle strobe, bit n = word n written

## Operation
- Map:
  - word 0: CTRL, RW
  - word 1: COEF, RW
  - word 2: DATA, RW
  - word 3: STATUS, RO; returns status_in; writes are discarded.
- Write FSM states:
  - W_IDLE: AWREADY=1, WREADY=1.
  - W_HAVE_A: address captured; AWREADY=0, WREADY=1.
  - W_HAVE_D: data and strobe captured; AWREADY=1, WREADY=0.
  - W_RESP: both ready outputs 0; BVALID=1.
- Write transitions:
  - AW and W may handshake in the same cycle or in either order.
  - On the edge completing the second handshake: the selected register is updated byte-wise per WSTRB, wr_pulse[n] is set for that one cycle, and the FSM enters W_RESP.
  - W_RESP leaves to W_IDLE on BVALID&&BREADY.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_DATA: ARREADY=0; RVALID=1.
- Read transitions:
  - On ARVALID&&ARREADY, RDATA is loaded from the addressed word (status_in for word 3) and the FSM moves to R_DATA.
  - R_DATA returns to R_IDLE on RREADY.
- Read and write FSMs are independent.
  - A read and a write to the same word in the same cycle: the read returns the pre-write value.
- BRESP/RRESP = 2'b00 (OKAY) unless the Configuration section applies.
- WSTRB=0 completes the handshake with OKAY, leaves the register unchanged, and still pulses wr_pulse.

## Timing
- Reset values:
  - All registers 0, wr_pulse 0.
  - AWREADY/WREADY/ARREADY 0; BVALID/RVALID 0; BRESP/RRESP 0; RDATA 0.
  - Both FSMs in IDLE; the ready outputs rise on the first edge after S_AXI_ARESET is sampled low.
- Write latency: BVALID and updated reg*_out are visible one cycle after the last of the AW/W handshakes.
- Read latency: RVALID/RDATA are valid one cycle after the AR handshake.
- Minimum throughput:
  - Writes: one per 2 cycles when BREADY is held high.
  - Reads: one per 2 cycles when RREADY is held high.
- RDATA, RRESP, BRESP are stable while their VALID is high and READY is low.
- Reset asserted mid-transaction: all state is abandoned and registers are cleared at that edge; no response is issued afterwards.

## Configuration
- FILTRO_AXIL_SLVERR_EN defined:
  - A write to word 3 returns BRESP=2'b10 (SLVERR) and does not pulse wr_pulse[3].
  - Any access with addr[1:0]≠0 returns SLVERR with no register update; reads return RDATA=0.
- FILTRO_AXIL_SLVERR_EN undefined:
  - All responses OKAY.
  - addr[1:0] ignored.
  - Word-3 writes silently discarded; wr_pulse[3] still pulses.

## Test plan
- Sequential writes 0x1,0x2,0x3 to addresses 0x0,0x4,0x8, then reads back -> RDATA 0x1,0x2,0x3, all RRESP OKAY; reg0..2_out match.
- W beat presented 3 cycles before AW, then AW 3 cycles before W -> both complete.
  - BVALID rises exactly one cycle after the later handshake.
  - wr_pulse is high for exactly one cycle.
- reg1=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> reg1 reads 0xFF34FF78.
- status_in=0xCAFE0003, read 0xC -> RDATA 0xCAFE0003. Then write 0x5 to 0xC:
  - With the macro: BRESP=SLVERR.
  - Without the macro: OKAY.
  - In both cases a subsequent read still returns status_in.
- BREADY/RREADY held low 10 cycles -> BVALID/RVALID and response data stay stable; AWREADY/WREADY/ARREADY stay 0; completion occurs on the first ready.
- Reset pulsed while in W_HAVE_A after reg0 has been written to 0xA -> reg0_out=0 and BVALID=0; a new full write then completes normally.
